color_sweep_ctrl: RTL and testbench
===================================

Name: color_sweep_ctrl

Overview:
Command-driven scheduler that sequences the RGBW colour generator. It accepts host commands over a valid/ready handshake and drives the generator's mode, colorIdx, white, lint and RGB inputs. Two command types are supported: direct RGBW writes, and timed hue sweeps that step colorIdx at a programmable rate. It sits between the register/SPI front end and the colour generator, and holds every generator input stable for at least one full generator pass.

Parameters:
TICK_DIV, 1000, clock cycles per rate tick (1..65535; 16-bit counter)
SETTLE, 260, minimum cycles colorIdx is held before the next step (1..511; 9-bit counter; must exceed the worst-case generator pass of about 224 cycles)
IDX_MAX, 8'hD8, highest legal hue index

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  00 direct, 01 sweep once, 10 stop, 11 sweep loop
cmd_start_idx  in  8  sweep start hue
cmd_end_idx  in  8  sweep end hue
cmd_rate  in  8  ticks per step (0 treated as 1)
cmd_white  in  8  white level
cmd_lint  in  8  intensity (bits [7:5] used by the generator)
cmd_red, cmd_green, cmd_blue  in  8 each  direct-mode RGB
gen_mode  out  8  00 idle, 21 direct, A4 sweep
gen_idx, gen_white, gen_lint, gen_red, gen_green, gen_blue  out  8 each  generator inputs
busy  out  1  high in any state other than IDLE
step_strobe  out  1  one-cycle pulse when gen_idx changes
done  out  1  one-cycle pulse at sweep end or stop

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, all counters 0; cmd_ready = 0 while reset is asserted, 1 on the first clk edge after release.
- Only registered values are latched at acceptance; all outputs are registered.
- States: IDLE, DIRECT, SW_HOLD, SW_LAST, SW_END.
- cmd_ready = 1 in IDLE, SW_HOLD and SW_LAST; 0 in DIRECT and SW_END.
- IDLE:
  - op 00: latch white/lint/RGB, gen_mode = 21; go to DIRECT.
  - op 01 or 11: go to SW_HOLD (see sweep load).
  - op 10: no action; no done pulse.
- DIRECT: hold for exactly 4 cycles, then gen_mode = 00 and return to IDLE. RGB/white/lint outputs keep their values.
- Sweep load:
  - Clamp start and end to IDX_MAX.
  - gen_idx = start; direction is up if end >= start, else down.
  - Latch white, lint and rate; gen_mode = A4; clear tick, settle and rate counters.
  - step_strobe pulses on load.
  - Go to SW_LAST if start == end, else SW_HOLD.
- SW_HOLD stepping:
  - settle counter saturates at SETTLE.
  - tick counter wraps at TICK_DIV and increments the rate counter on wrap.
  - Step when settle == SETTLE and rate counter >= rate: gen_idx +/- 1, counters cleared, step_strobe pulses.
  - If the new idx == end, go to SW_LAST.
- SW_LAST: hold idx for SETTLE cycles.
  - Loop mode (11): reload start (step_strobe pulses) and go to SW_HOLD.
  - Once mode (01): go to SW_END.
- SW_END: gen_mode = 00, done pulses, next state IDLE. gen_idx keeps the end value.
- Stop (op 10) in SW_HOLD or SW_LAST: gen_mode = 00 next cycle, done pulses, state IDLE, gen_idx frozen.
- Sweep or direct command in SW_HOLD or SW_LAST: preempts the current sweep without a done pulse.
  - Sweep is reloaded.
  - Direct goes to DIRECT.
- Simultaneous step condition and accepted command: the command wins; no step, no step_strobe.
- No wrap-around of gen_idx; it never leaves the range 0..IDX_MAX.
- Reset mid-sweep: immediate return to reset values; no done pulse.

Test Plan:
(Bench runs with TICK_DIV=4 and SETTLE=8.)
1. Reset released, then op 00 with RGB = 10/20/30, white = 40 -> gen_mode = 21 for 4 cycles, then 00; gen_red = 10, gen_white = 40 held; busy high for 4 cycles; no done pulse.
2. Sweep once, start 5, end 8, rate 3 -> gen_idx takes values 5, 6, 7, 8, each step 12 cycles apart; 4 step_strobe pulses; done 8 cycles after idx = 8; gen_mode returns to 00.
3. Sweep once, start 0xF0, end 0x02 -> start is clamped to 0xD8 and the sweep counts down; final idx = 2; no value exceeds 0xD8.
4. Loop mode, start 3, end 4, rate 0 -> repeating sequence 3, 4, 3, 4; stop issued during idx 4 -> gen_mode = 00 next cycle, single done pulse, gen_idx stays 4.
5. Sweep command issued in the same cycle the step condition fires -> new start idx loaded, no increment, exactly one step_strobe.
6. Reset asserted mid-sweep between clock edges -> all outputs 0 immediately (asynchronous); cmd_ready is 0 until the first edge after release.

Source files
------------

// File: rtl/color_sweep_ctrl.sv
// Command-driven scheduler for the RGBW colour generator: direct RGBW writes and
// timed hue sweeps, with every generator input held for at least SETTLE cycles.
module color_sweep_ctrl #(
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned SETTLE   = 260,
   parameter logic [7:0]  IDX_MAX  = 8'hD8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_start_idx,
   input  logic [7:0] cmd_end_idx,
   input  logic [7:0] cmd_rate,
   input  logic [7:0] cmd_white,
   input  logic [7:0] cmd_lint,
   input  logic [7:0] cmd_red,
   input  logic [7:0] cmd_green,
   input  logic [7:0] cmd_blue,
   output logic [7:0] gen_mode,
   output logic [7:0] gen_idx,
   output logic [7:0] gen_white,
   output logic [7:0] gen_lint,
   output logic [7:0] gen_red,
   output logic [7:0] gen_green,
   output logic [7:0] gen_blue,
   output logic       busy,
   output logic       step_strobe,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, DIRECT, SW_HOLD, SW_LAST, SW_END} state_t;

   localparam logic [1:0]  OP_DIRECT   = 2'b00;
   localparam logic [1:0]  OP_STOP     = 2'b10;
   localparam logic [1:0]  OP_LOOP     = 2'b11;
   localparam logic [7:0]  MODE_IDLE   = 8'h00;
   localparam logic [7:0]  MODE_DIRECT = 8'h21;
   localparam logic [7:0]  MODE_SWEEP  = 8'hA4;
   localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);
   localparam logic [8:0]  SETTLE_MAX  = 9'(SETTLE);
   localparam logic [8:0]  SETTLE_LAST = 9'(SETTLE - 1);
   localparam logic [8:0]  DIRECT_LAST = 9'd3;

   state_t      state_q, state_d;
   logic [15:0] tick_q, tick_d;
   logic [8:0]  settle_q, settle_d;
   logic [7:0]  rate_cnt_q, rate_cnt_d;
   logic [7:0]  rate_q, rate_d;
   logic [7:0]  start_q, start_d;
   logic [7:0]  end_q, end_d;
   logic        up_q, up_d;
   logic        loop_q, loop_d;

   logic [7:0]  mode_d, idx_d, white_d, lint_d, red_d, green_d, blue_d;
   logic        strobe_d, done_d;

   logic        accept, tick_wrap, settle_ok, step_ok, do_load;
   logic [7:0]  start_c, end_c, rate_eff, ld_start, ld_end;

   assign accept    = cmd_valid && cmd_ready;
   assign start_c   = (cmd_start_idx > IDX_MAX) ? IDX_MAX : cmd_start_idx;
   assign end_c     = (cmd_end_idx > IDX_MAX) ? IDX_MAX : cmd_end_idx;
   assign rate_eff  = (rate_q == 8'd0) ? 8'd1 : rate_q;
   assign tick_wrap = (tick_q == TICK_LAST);
   // Both tests look at the count this edge completes, so a hold lasts exactly SETTLE cycles.
   assign settle_ok = (settle_q >= SETTLE_LAST);
   assign step_ok   = settle_ok &&
                      (({1'b0, rate_cnt_q} + {8'd0, tick_wrap}) >= {1'b0, rate_eff});

   always_comb begin
      // NOTE: every signal written here is defaulted first so no path can infer a latch.
      state_d    = state_q;
      tick_d     = tick_q;
      settle_d   = settle_q;
      rate_cnt_d = rate_cnt_q;
      rate_d     = rate_q;
      start_d    = start_q;
      end_d      = end_q;
      up_d       = up_q;
      loop_d     = loop_q;
      mode_d     = gen_mode;
      idx_d      = gen_idx;
      white_d    = gen_white;
      lint_d     = gen_lint;
      red_d      = gen_red;
      green_d    = gen_green;
      blue_d     = gen_blue;
      strobe_d   = 1'b0;
      done_d     = 1'b0;
      do_load    = 1'b0;
      ld_start   = start_q;
      ld_end     = end_q;

      if (accept) begin
         // An accepted command always beats a pending step or hold expiry.
         case (cmd_op)
            OP_DIRECT: begin
               white_d  = cmd_white;
               lint_d   = cmd_lint;
               red_d    = cmd_red;
               green_d  = cmd_green;
               blue_d   = cmd_blue;
               mode_d   = MODE_DIRECT;
               settle_d = '0;
               state_d  = DIRECT;
            end
            OP_STOP: begin
               if (state_q != IDLE) begin
                  mode_d  = MODE_IDLE;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: begin
               do_load  = 1'b1;
               ld_start = start_c;
               ld_end   = end_c;
               white_d  = cmd_white;
               lint_d   = cmd_lint;
               rate_d   = cmd_rate;
               loop_d   = (cmd_op == OP_LOOP);
            end
         endcase
      end else begin
         case (state_q)
            DIRECT: begin
               if (settle_q == DIRECT_LAST) begin
                  mode_d  = MODE_IDLE;
                  state_d = IDLE;
               end else begin
                  settle_d = settle_q + 9'd1;
               end
            end
            SW_HOLD: begin
               settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 9'd1;
               tick_d   = tick_wrap ? '0 : tick_q + 16'd1;
               if (tick_wrap && rate_cnt_q != 8'hFF) rate_cnt_d = rate_cnt_q + 8'd1;
               if (step_ok) begin
                  idx_d      = up_q ? gen_idx + 8'd1 : gen_idx - 8'd1;
                  tick_d     = '0;
                  settle_d   = '0;
                  rate_cnt_d = '0;
                  strobe_d   = 1'b1;
                  if (idx_d == end_q) state_d = SW_LAST;
               end
            end
            SW_LAST: begin
               settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 9'd1;
               if (settle_ok) begin
                  if (loop_q) begin
                     do_load = 1'b1;
                  end else begin
                     mode_d  = MODE_IDLE;
                     done_d  = 1'b1;
                     state_d = SW_END;
                  end
               end
            end
            SW_END:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      if (do_load) begin
         idx_d      = ld_start;
         start_d    = ld_start;
         end_d      = ld_end;
         up_d       = (ld_end >= ld_start);
         tick_d     = '0;
         settle_d   = '0;
         rate_cnt_d = '0;
         strobe_d   = 1'b1;
         mode_d     = MODE_SWEEP;
         state_d    = (ld_start == ld_end) ? SW_LAST : SW_HOLD;
      end
   end

   // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         settle_q    <= '0;
         rate_cnt_q  <= '0;
         rate_q      <= '0;
         start_q     <= '0;
         end_q       <= '0;
         up_q        <= 1'b0;
         loop_q      <= 1'b0;
         gen_mode    <= '0;
         gen_idx     <= '0;
         gen_white   <= '0;
         gen_lint    <= '0;
         gen_red     <= '0;
         gen_green   <= '0;
         gen_blue    <= '0;
         step_strobe <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         cmd_ready   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         settle_q    <= settle_d;
         rate_cnt_q  <= rate_cnt_d;
         rate_q      <= rate_d;
         start_q     <= start_d;
         end_q       <= end_d;
         up_q        <= up_d;
         loop_q      <= loop_d;
         gen_mode    <= mode_d;
         gen_idx     <= idx_d;
         gen_white   <= white_d;
         gen_lint    <= lint_d;
         gen_red     <= red_d;
         gen_green   <= green_d;
         gen_blue    <= blue_d;
         step_strobe <= strobe_d;
         done        <= done_d;
         busy        <= (state_d != IDLE);
         cmd_ready   <= (state_d == IDLE) || (state_d == SW_HOLD) || (state_d == SW_LAST);
      end
   end

endmodule

// File: tb/tb_color_sweep_ctrl.sv
// Directed bench for color_sweep_ctrl with TICK_DIV=4, SETTLE=8; expected
// cycle counts are hand-derived from the command/step timing rules.
module tb_color_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_start_idx = '0, cmd_end_idx = '0, cmd_rate = '0;
   logic [7:0] cmd_white = '0, cmd_lint = '0;
   logic [7:0] cmd_red = '0, cmd_green = '0, cmd_blue = '0;
   logic [7:0] gen_mode, gen_idx, gen_white, gen_lint, gen_red, gen_green, gen_blue;
   logic       busy, step_strobe, done;

   int n_assert = 0;
   int n_fail   = 0;

   int         st_cyc[$];
   logic [7:0] st_idx[$];
   int         done_cnt;
   int         done_cyc;
   logic [7:0] max_idx;

   color_sweep_ctrl #(.TICK_DIV(4), .SETTLE(8), .IDX_MAX(8'hD8)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_start_idx(cmd_start_idx), .cmd_end_idx(cmd_end_idx), .cmd_rate(cmd_rate),
      .cmd_white(cmd_white), .cmd_lint(cmd_lint),
      .cmd_red(cmd_red), .cmd_green(cmd_green), .cmd_blue(cmd_blue),
      .gen_mode(gen_mode), .gen_idx(gen_idx), .gen_white(gen_white), .gen_lint(gen_lint),
      .gen_red(gen_red), .gen_green(gen_green), .gen_blue(gen_blue),
      .busy(busy), .step_strobe(step_strobe), .done(done)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   function automatic int q_cyc(input int k);
      return (k < st_cyc.size()) ? st_cyc[k] : -1;
   endfunction

   function automatic logic [7:0] q_idx(input int k);
      return (k < st_idx.size()) ? st_idx[k] : 8'hxx;
   endfunction

   task automatic send(input string tag, input logic [1:0] op, input logic [7:0] s_idx,
                       input logic [7:0] e_idx, input logic [7:0] rate, input logic [7:0] white,
                       input logic [7:0] lint, input logic [7:0] red, input logic [7:0] green,
                       input logic [7:0] blue);
      for (int i = 0; i < 10 && cmd_ready !== 1'b1; i++) step_clk();
      check({tag, " ready"}, {31'd0, cmd_ready}, 32'd1);
      cmd_op        = op;
      cmd_start_idx = s_idx;
      cmd_end_idx   = e_idx;
      cmd_rate      = rate;
      cmd_white     = white;
      cmd_lint      = lint;
      cmd_red       = red;
      cmd_green     = green;
      cmd_blue      = blue;
      cmd_valid     = 1'b1;
      step_clk();
      cmd_valid     = 1'b0;
   endtask

   // Records strobes (cycle, idx) and done pulses, cycles counted from the last send.
   task automatic watch(input int max_cyc, input bit until_done);
      st_cyc.delete();
      st_idx.delete();
      done_cnt = 0;
      done_cyc = -1;
      max_idx  = gen_idx;
      for (int c = 1; c <= max_cyc; c++) begin
         step_clk();
         if (gen_idx > max_idx) max_idx = gen_idx;
         if (step_strobe) begin
            st_cyc.push_back(c);
            st_idx.push_back(gen_idx);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
            if (until_done) break;
         end
      end
   endtask

   initial begin
      int errs;
      int done_seen;

      // Reset state
      #1 reset = 1'b1;
      #1;
      check("rst mode", {24'd0, gen_mode}, 32'h00);
      check("rst idx", {24'd0, gen_idx}, 32'h00);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst ready", {31'd0, cmd_ready}, 32'd0);
      step_clk();
      check("rst ready after edge", {31'd0, cmd_ready}, 32'd0);
      reset = 1'b0;
      check("ready before first edge", {31'd0, cmd_ready}, 32'd0);
      step_clk();
      check("ready after release", {31'd0, cmd_ready}, 32'd1);

      // 1. Direct write
      send("t1", 2'b00, 8'd0, 8'd0, 8'd0, 8'd40, 8'hE0, 8'd10, 8'd20, 8'd30);
      check("t1 mode", {24'd0, gen_mode}, 32'h21);
      check("t1 red", {24'd0, gen_red}, 32'd10);
      check("t1 busy", {31'd0, busy}, 32'd1);
      check("t1 ready low", {31'd0, cmd_ready}, 32'd0);
      done_seen = done ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         step_clk();
         check("t1 mode held", {24'd0, gen_mode}, 32'h21);
         if (done) done_seen++;
      end
      step_clk();
      if (done) done_seen++;
      check("t1 mode end", {24'd0, gen_mode}, 32'h00);
      check("t1 busy end", {31'd0, busy}, 32'd0);
      check("t1 white", {24'd0, gen_white}, 32'd40);
      check("t1 green", {24'd0, gen_green}, 32'd20);
      check("t1 blue", {24'd0, gen_blue}, 32'd30);
      check("t1 no done", done_seen, 32'd0);

      // 2. Sweep once 5 -> 8, rate 3
      send("t2", 2'b01, 8'd5, 8'd8, 8'd3, 8'h11, 8'h60, 8'd0, 8'd0, 8'd0);
      check("t2 load idx", {24'd0, gen_idx}, 32'd5);
      check("t2 load strobe", {31'd0, step_strobe}, 32'd1);
      check("t2 mode", {24'd0, gen_mode}, 32'hA4);
      check("t2 white", {24'd0, gen_white}, 32'h11);
      watch(100, 1'b1);
      check("t2 strobes", st_cyc.size(), 32'd3);
      check("t2 step0 cyc", q_cyc(0), 32'd12);
      check("t2 step0 idx", {24'd0, q_idx(0)}, 32'd6);
      check("t2 step1 cyc", q_cyc(1), 32'd24);
      check("t2 step1 idx", {24'd0, q_idx(1)}, 32'd7);
      check("t2 step2 cyc", q_cyc(2), 32'd36);
      check("t2 step2 idx", {24'd0, q_idx(2)}, 32'd8);
      check("t2 done cyc", done_cyc, 32'd44);
      check("t2 mode at done", {24'd0, gen_mode}, 32'h00);
      check("t2 final idx", {24'd0, gen_idx}, 32'd8);
      step_clk();
      check("t2 done one cycle", {31'd0, done}, 32'd0);
      check("t2 busy end", {31'd0, busy}, 32'd0);

      // 3. Clamped start, downward sweep F0 -> 02
      send("t3", 2'b01, 8'hF0, 8'h02, 8'd1, 8'h22, 8'h20, 8'd0, 8'd0, 8'd0);
      check("t3 clamp idx", {24'd0, gen_idx}, 32'hD8);
      watch(2000, 1'b1);
      check("t3 strobes", st_cyc.size(), 32'd214);
      errs = 0;
      for (int k = 0; k < st_cyc.size(); k++) begin
         if (st_cyc[k] != 8 * (k + 1) || st_idx[k] != 8'(8'hD7 - k)) errs++;
      end
      check("t3 step sequence errs", errs, 32'd0);
      check("t3 max idx", {24'd0, max_idx}, 32'hD8);
      check("t3 done cyc", done_cyc, 32'd1720);
      check("t3 final idx", {24'd0, gen_idx}, 32'h02);

      // 3b. Both ends clamp to IDX_MAX -> straight to the final hold
      send("t3b", 2'b01, 8'hE0, 8'hFF, 8'd5, 8'h33, 8'h40, 8'd0, 8'd0, 8'd0);
      check("t3b idx", {24'd0, gen_idx}, 32'hD8);
      watch(20, 1'b1);
      check("t3b no steps", st_cyc.size(), 32'd0);
      check("t3b done cyc", done_cyc, 32'd8);

      // 4. Loop 3 <-> 4, rate 0, then stop while idx = 4
      send("t4", 2'b11, 8'd3, 8'd4, 8'd0, 8'h44, 8'h80, 8'd0, 8'd0, 8'd0);
      check("t4 load idx", {24'd0, gen_idx}, 32'd3);
      watch(26, 1'b0);
      check("t4 strobes", st_cyc.size(), 32'd3);
      check("t4 s0 cyc", q_cyc(0), 32'd8);
      check("t4 s0 idx", {24'd0, q_idx(0)}, 32'd4);
      check("t4 s1 cyc", q_cyc(1), 32'd16);
      check("t4 s1 idx", {24'd0, q_idx(1)}, 32'd3);
      check("t4 s2 cyc", q_cyc(2), 32'd24);
      check("t4 s2 idx", {24'd0, q_idx(2)}, 32'd4);
      check("t4 no done in loop", done_cnt, 32'd0);
      send("t4 stop", 2'b10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      check("t4 stop mode", {24'd0, gen_mode}, 32'h00);
      check("t4 stop done", {31'd0, done}, 32'd1);
      check("t4 stop idx", {24'd0, gen_idx}, 32'd4);
      check("t4 stop busy", {31'd0, busy}, 32'd0);
      step_clk();
      check("t4 done single", {31'd0, done}, 32'd0);
      check("t4 idx frozen", {24'd0, gen_idx}, 32'd4);

      // 5. Sweep command in the same cycle as the step condition
      send("t5", 2'b01, 8'd5, 8'd8, 8'd3, 8'h55, 8'hA0, 8'd0, 8'd0, 8'd0);
      watch(11, 1'b0);
      check("t5 no early step", st_cyc.size(), 32'd0);
      send("t5 preempt", 2'b01, 8'h20, 8'h22, 8'd2, 8'h66, 8'hC0, 8'd0, 8'd0, 8'd0);
      check("t5 new idx", {24'd0, gen_idx}, 32'h20);
      check("t5 strobe", {31'd0, step_strobe}, 32'd1);
      check("t5 no done", {31'd0, done}, 32'd0);
      watch(8, 1'b0);
      check("t5 next strobes", st_cyc.size(), 32'd1);
      check("t5 next cyc", q_cyc(0), 32'd8);
      check("t5 next idx", {24'd0, q_idx(0)}, 32'h21);

      // 6. Asynchronous reset mid-sweep
      watch(5, 1'b0);
      #3 reset = 1'b1;
      #1;
      check("t6 mode", {24'd0, gen_mode}, 32'h00);
      check("t6 idx", {24'd0, gen_idx}, 32'h00);
      check("t6 white", {24'd0, gen_white}, 32'h00);
      check("t6 lint", {24'd0, gen_lint}, 32'h00);
      check("t6 red", {24'd0, gen_red}, 32'h00);
      check("t6 busy", {31'd0, busy}, 32'd0);
      check("t6 ready", {31'd0, cmd_ready}, 32'd0);
      step_clk();
      reset = 1'b0;
      check("t6 ready after release", {31'd0, cmd_ready}, 32'd0);
      check("t6 no done", {31'd0, done}, 32'd0);
      step_clk();
      check("t6 ready first edge", {31'd0, cmd_ready}, 32'd1);
      check("t6 mode idle", {24'd0, gen_mode}, 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
